// File: rtl/game_pkg.sv
// ============================================================================
// Module  : game_pkg
// Brief   : Shared types and constants for the pipe scroller game slice.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package game_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCROLL = 2'd1,
        FROZEN = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [9:0]  SCORE_MAX = 10'd999;
    localparam int unsigned COORD_W   = 11;

endpackage

`default_nettype wire

// File: rtl/gap_lfsr.sv
// ============================================================================
// Module  : gap_lfsr
// Brief   : 16-bit Fibonacci LFSR folded into the legal pipe-gap y range.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gap_lfsr
    import game_pkg::*;
#(
    parameter int Y_MIN = 100,
    parameter int Y_MAX = 300
) (
    input  logic               game_clk,
    input  logic               reset,
    input  logic               advance,
    output logic [COORD_W-1:0] gap_y
);

    localparam logic [COORD_W-1:0] C_Y_MIN = COORD_W'(Y_MIN);
    localparam logic [COORD_W-1:0] C_SPAN  = COORD_W'(Y_MAX - Y_MIN);

    logic [15:0]        r_lfsr;
    logic               w_fb;
    logic [COORD_W-1:0] w_r;

    // Taps 16,14,13,11 in right-shift form: bits 0,2,3,5 feed bit 15.
    assign w_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    assign w_r  = {{(COORD_W-8){1'b0}}, r_lfsr[7:0]};

    always_ff @(posedge game_clk) begin
        if (reset) begin
            r_lfsr <= LFSR_SEED;
        end else if (advance) begin
            r_lfsr <= {w_fb, r_lfsr[15:1]};
        end
    end

    always_comb begin
        if (w_r <= C_SPAN) begin
            gap_y = C_Y_MIN + w_r;
        end else begin
            gap_y = C_Y_MIN + w_r - C_SPAN - COORD_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipe_scroller.sv
// ============================================================================
// Module  : pipe_scroller
// Brief   : Scrolls NUM_PIPES pipes leftwards, wraps them with fresh gaps, scores.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_scroller
    import game_pkg::*;
#(
    parameter int NUM_PIPES = 2,
    parameter int SCREEN_W  = 640,
    parameter int PIPE_W    = 40,
    parameter int Y_MIN     = 100,
    parameter int Y_MAX     = 300,
    parameter int SPEED_W   = 4
) (
    input  logic                                game_clk,
    input  logic                                reset,
    input  logic                                enable,
    input  logic                                freeze,
    input  logic                                restart,
    input  logic [SPEED_W-1:0]                  speed,
    input  logic [COORD_W-1:0]                  bird_x,
    output logic [NUM_PIPES-1:0][COORD_W-1:0]   pipe_x,
    output logic [NUM_PIPES-1:0][COORD_W-1:0]   pipe_y,
    output logic                                score_pulse,
    output logic [9:0]                          score,
    output logic                                frozen
);

    localparam int                 SPACING  = SCREEN_W / NUM_PIPES;
    localparam logic [COORD_W-1:0] C_SCREEN = COORD_W'(SCREEN_W);
    localparam logic [COORD_W-1:0] C_Y_INIT = COORD_W'((Y_MIN + Y_MAX) / 2);
    localparam logic [COORD_W:0]   C_PIPE_W = (COORD_W+1)'(PIPE_W);

    state_t                             r_state;
    logic                               w_reinit;
    logic                               w_move;
    logic                               w_score_evt;
    logic [COORD_W-1:0]                 w_speed;
    logic [COORD_W-1:0]                 w_gap_y;
    logic [COORD_W:0]                   w_bird;
    logic [NUM_PIPES-1:0]               w_wrap;
    logic [NUM_PIPES-1:0]               w_hit;
    logic [NUM_PIPES-1:0][COORD_W-1:0]  w_next_x;

    assign w_reinit = reset || ((r_state == FROZEN) && restart);
    assign w_move   = (r_state == SCROLL) && enable && !freeze;
    assign w_speed  = {{(COORD_W-SPEED_W){1'b0}}, speed};
    assign w_bird   = {1'b0, bird_x};

    gap_lfsr #(
        .Y_MIN (Y_MIN),
        .Y_MAX (Y_MAX)
    ) u_gap_lfsr (
        .game_clk (game_clk),
        .reset    (w_reinit),
        .advance  (w_move),
        .gap_y    (w_gap_y)
    );

    for (genvar i = 0; i < NUM_PIPES; i++) begin : g_pipe
        logic [COORD_W:0] w_old_edge;
        logic [COORD_W:0] w_new_edge;

        assign w_wrap[i]   = pipe_x[i] < w_speed;
        assign w_next_x[i] = w_wrap[i] ? (pipe_x[i] + C_SCREEN - w_speed)
                                       : (pipe_x[i] - w_speed);
        assign w_old_edge  = {1'b0, pipe_x[i]} + C_PIPE_W;
        assign w_new_edge  = {1'b0, w_next_x[i]} + C_PIPE_W;
        // A wrapping pipe jumps right, so it can never be "passing" the bird.
        assign w_hit[i]    = !w_wrap[i] && (w_old_edge >= w_bird) && (w_new_edge < w_bird);
    end

    assign w_score_evt = |w_hit;

    always_ff @(posedge game_clk) begin
        if (w_reinit) begin
            r_state     <= IDLE;
            score       <= '0;
            score_pulse <= 1'b0;
            frozen      <= 1'b0;
            for (int i = 0; i < NUM_PIPES; i++) begin
                pipe_x[i] <= COORD_W'((i + 1) * SPACING - 1);
                pipe_y[i] <= C_Y_INIT;
            end
        end else begin
            score_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (enable) begin
                        r_state <= SCROLL;
                    end
                end
                SCROLL: begin
                    if (freeze) begin
                        r_state <= FROZEN;
                        frozen  <= 1'b1;
                    end else if (!enable) begin
                        r_state <= IDLE;
                    end else begin
                        for (int i = 0; i < NUM_PIPES; i++) begin
                            pipe_x[i] <= w_next_x[i];
                            if (w_wrap[i]) begin
                                pipe_y[i] <= w_gap_y;
                            end
                        end
                        score_pulse <= w_score_evt;
                        if (w_score_evt && (score != SCORE_MAX)) begin
                            score <= score + 10'd1;
                        end
                    end
                end
                FROZEN: begin
                    frozen <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    frozen  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipe_scroller.sv
// ============================================================================
// Module  : tb_pipe_scroller
// Brief   : Scoreboard bench; a behavioural model queues expected outputs per tick.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_scroller;

    logic              game_clk;
    logic              reset;
    logic              enable;
    logic              freeze;
    logic              restart;
    logic [3:0]        speed;
    logic [10:0]       bird_x;
    logic [1:0][10:0]  pipe_x;
    logic [1:0][10:0]  pipe_y;
    logic              score_pulse;
    logic [9:0]        score;
    logic              frozen;

    pipe_scroller dut (
        .game_clk    (game_clk),
        .reset       (reset),
        .enable      (enable),
        .freeze      (freeze),
        .restart     (restart),
        .speed       (speed),
        .bird_x      (bird_x),
        .pipe_x      (pipe_x),
        .pipe_y      (pipe_y),
        .score_pulse (score_pulse),
        .score       (score),
        .frozen      (frozen)
    );

    initial game_clk = 1'b0;
    always #5 game_clk = ~game_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: 0 idle, 1 scroll, 2 frozen.
    int m_st, m_lfsr, m_score, m_pulse, m_frz;
    int m_x[2];
    int m_y[2];

    logic [55:0] exp_q[$];
    logic [55:0] e;
    logic [55:0] obs;

    function automatic int fold(input int l);
        int r;
        r = l & 255;
        if (r <= 200) return 100 + r;
        return 100 + r - 201;
    endfunction

    function automatic int lfsr_next(input int l);
        int b;
        b = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
        return (l >> 1) | (b << 15);
    endfunction

    task automatic model_update();
        int gap, old, evt;
        if (reset || (m_st == 2 && restart)) begin
            m_st = 0; m_x[0] = 319; m_x[1] = 639; m_y[0] = 200; m_y[1] = 200;
            m_lfsr = 'hACE1; m_score = 0; m_pulse = 0; m_frz = 0;
        end else begin
            m_pulse = 0;
            if (m_st == 0) begin
                if (enable) m_st = 1;
            end else if (m_st == 1) begin
                if (freeze) begin
                    m_st = 2; m_frz = 1;
                end else if (!enable) begin
                    m_st = 0;
                end else begin
                    gap = fold(m_lfsr);
                    evt = 0;
                    for (int i = 0; i < 2; i++) begin
                        if (m_x[i] < int'(speed)) begin
                            m_x[i] = m_x[i] + 640 - int'(speed);
                            m_y[i] = gap;
                        end else begin
                            old = m_x[i];
                            m_x[i] = m_x[i] - int'(speed);
                            if (old + 40 >= int'(bird_x) && m_x[i] + 40 < int'(bird_x)) evt = 1;
                        end
                    end
                    m_lfsr = lfsr_next(m_lfsr);
                    m_pulse = evt;
                    if (evt && m_score < 999) m_score++;
                end
            end
        end
    endtask

    task automatic step();
        model_update();
        exp_q.push_back({11'(m_x[0]), 11'(m_x[1]), 11'(m_y[0]), 11'(m_y[1]),
                         10'(m_score), 1'(m_pulse), 1'(m_frz)});
        @(posedge game_clk);
        #1;
        obs = {pipe_x[0], pipe_x[1], pipe_y[0], pipe_y[1], score, score_pulse, frozen};
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL reset_state: got %h want %h", obs, e); end
        n_cmp++;
        if (pipe_x[0] !== 11'd319 || pipe_x[1] !== 11'd639 || pipe_y[0] !== 11'd200 ||
            pipe_y[1] !== 11'd200 || score !== 10'd0 || frozen !== 1'b0 || score_pulse !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_values: got x=%0d,%0d y=%0d,%0d score=%0d frozen=%b want 319,639 200,200 0 0",
                     pipe_x[0], pipe_x[1], pipe_y[0], pipe_y[1], score, frozen);
        end
        reset = 1'b0;
    endtask

    task automatic test_start();
        enable = 1'b1;
        speed  = 4'd1;
        step();
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL start_enter: got %h want %h", obs, e); end
        step();
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e || pipe_x[0] !== 11'd318 || pipe_x[1] !== 11'd638) begin
            n_bad++;
            $display("FAIL start_move: got x=%0d,%0d (%h) want 318,638 (%h)", pipe_x[0], pipe_x[1], obs, e);
        end
    endtask

    task automatic test_score();
        for (int k = 0; k < 400 && m_x[0] != 59; k++) begin
            step();
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL score_run: got %h want %h", obs, e); end
            if (m_x[0] == 60) begin
                n_cmp++;
                if (score_pulse !== 1'b0) begin n_bad++; $display("FAIL score_early: pulse=%b want 0", score_pulse); end
            end
        end
        n_cmp++;
        if (pipe_x[0] !== 11'd59 || score_pulse !== 1'b1 || score !== 10'd1) begin
            n_bad++;
            $display("FAIL score_event: got x=%0d pulse=%b score=%0d want 59 1 1", pipe_x[0], score_pulse, score);
        end
        step();
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e || score_pulse !== 1'b0 || score !== 10'd1) begin
            n_bad++;
            $display("FAIL score_one_tick: got pulse=%b score=%0d want 0 1", score_pulse, score);
        end
    endtask

    task automatic test_wrap();
        int gap;
        for (int k = 0; k < 100 && m_x[0] != 2; k++) begin
            step();
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL wrap_approach: got %h want %h", obs, e); end
        end
        speed = 4'd3;
        gap = fold(m_lfsr);
        step();
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL wrap_state: got %h want %h", obs, e); end
        n_cmp++;
        if (pipe_x[0] !== 11'd639 || pipe_y[0] < 11'd100 || pipe_y[0] > 11'd300 ||
            pipe_y[0] !== 11'(gap) || score_pulse !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap_values: got x=%0d y=%0d pulse=%b want 639 %0d 0",
                     pipe_x[0], pipe_y[0], score_pulse, gap);
        end
    endtask

    task automatic test_freeze();
        freeze = 1'b1;
        enable = 1'b1;
        step();
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e || frozen !== 1'b1) begin
            n_bad++; $display("FAIL freeze_enter: got %h frozen=%b want %h", obs, frozen, e);
        end
        freeze = 1'b0;
        enable = 1'b0;
        step();
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e || frozen !== 1'b1) begin
            n_bad++; $display("FAIL freeze_hold: got %h want %h", obs, e);
        end
        restart = 1'b1;
        step();
        restart = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e || pipe_x[0] !== 11'd319 || pipe_x[1] !== 11'd639 || pipe_y[0] !== 11'd200 ||
            pipe_y[1] !== 11'd200 || score !== 10'd0 || frozen !== 1'b0) begin
            n_bad++; $display("FAIL restart_init: got %h want %h", obs, e);
        end
    endtask

    task automatic test_idle_hold();
        enable = 1'b1;
        speed  = 4'd5;
        step();
        e = exp_q.pop_front();
        step();
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e || pipe_x[0] !== 11'd314) begin
            n_bad++; $display("FAIL idle_move: got x0=%0d want 314", pipe_x[0]);
        end
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e || pipe_x[0] !== 11'd314 || pipe_x[1] !== 11'd634) begin
                n_bad++; $display("FAIL idle_hold: got x=%0d,%0d want 314,634", pipe_x[0], pipe_x[1]);
            end
        end
    endtask

    task automatic test_speed_zero();
        enable = 1'b1;
        speed  = 4'd0;
        for (int k = 0; k < 4; k++) begin
            step();
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e || pipe_x[0] !== 11'd314) begin
                n_bad++; $display("FAIL speed_zero: got %h want %h", obs, e);
            end
        end
    endtask

    task automatic test_saturate();
        int pre;
        bit done;
        done  = 1'b0;
        speed = 4'd15;
        for (int k = 0; k < 40000 && !done; k++) begin
            pre = m_score;
            step();
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL saturate_run: got %h want %h", obs, e); end
            if (pre == 999 && m_pulse == 1) done = 1'b1;
        end
        n_cmp++;
        if (!done || score !== 10'd999 || score_pulse !== 1'b1) begin
            n_bad++;
            $display("FAIL saturate_event: got score=%0d pulse=%b reached=%b want 999 1 1", score, score_pulse, done);
        end
    endtask

    task automatic test_reset_midscroll();
        enable = 1'b1;
        speed  = 4'd7;
        reset  = 1'b1;
        step();
        reset  = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e || pipe_x[0] !== 11'd319 || score !== 10'd0 || score_pulse !== 1'b0) begin
            n_bad++; $display("FAIL reset_midscroll: got %h want %h", obs, e);
        end
    endtask

    initial begin
        reset   = 1'b0;
        enable  = 1'b0;
        freeze  = 1'b0;
        restart = 1'b0;
        speed   = 4'd0;
        bird_x  = 11'd100;
        m_st = 0; m_lfsr = 'hACE1; m_score = 0; m_pulse = 0; m_frz = 0;
        m_x[0] = 0; m_x[1] = 0; m_y[0] = 0; m_y[1] = 0;
        #2;
        test_reset();
        test_start();
        test_score();
        test_wrap();
        test_freeze();
        test_idle_hold();
        test_speed_zero();
        test_saturate();
        test_reset_midscroll();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_scroller.md
PIPE_SCROLLER -- requirements
Module: pipe_scroller

Interface
REQ-001 Parameter NUM_PIPES, default 2: number of pipes scrolled in parallel (1..8).
REQ-002 Parameter SCREEN_W, default 640: horizontal scroll span in pixels.
REQ-003 Parameter PIPE_W, default 40: pipe width in pixels.
REQ-004 Parameter Y_MIN, default 100: lowest legal gap y.
REQ-005 Parameter Y_MAX, default 300: highest legal gap y; (Y_MAX-Y_MIN+1) SHALL be in 128..256.
REQ-006 Parameter SPEED_W, default 4: width of the speed input.
REQ-007 Port game_clk, input, 1: game tick clock; all state changes on its rising edge.
REQ-008 Port reset, input, 1: synchronous, active-high reset.
REQ-009 Port enable, input, 1: game running (from the game manager).
REQ-010 Port freeze, input, 1: collision; stops scrolling.
REQ-011 Port restart, input, 1: leave frozen state and re-initialise.
REQ-012 Port speed, input, SPEED_W: pixels moved per tick.
REQ-013 Port bird_x, input, 11: bird left x, used for scoring.
REQ-014 Port pipe_x, output, NUM_PIPES x 11: left x of each pipe.
REQ-015 Port pipe_y, output, NUM_PIPES x 11: gap y of each pipe.
REQ-016 Port score_pulse, output, 1: high for one tick when a pipe is passed.
REQ-017 Port score, output, 10: passed-pipe count.
REQ-018 Port frozen, output, 1: high in FROZEN state.

Function
REQ-019 FSM states SHALL be IDLE, SCROLL and FROZEN.
REQ-020 Transitions SHALL be: IDLE->SCROLL on enable; SCROLL->FROZEN on freeze; SCROLL->IDLE on ~enable with positions held; FROZEN->IDLE on restart with full re-initialisation.
REQ-021 If freeze and enable are high together, freeze SHALL win.
REQ-022 In SCROLL, every pipe SHALL move in the same tick: pipe_x[i] <= pipe_x[i] - speed.
REQ-023 Wrap rule: if pipe_x[i] < speed, then pipe_x[i] <= pipe_x[i] + SCREEN_W - speed, which preserves spacing exactly.
REQ-024 On wrap, pipe_y[i] SHALL be reloaded from the LFSR in the same tick.
REQ-025 LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1, advancing once per SCROLL tick.
REQ-026 Gap y from the LFSR SHALL be r = lfsr[7:0]; y = Y_MIN + r if r <= Y_MAX-Y_MIN, else Y_MIN + r - (Y_MAX-Y_MIN+1).
REQ-027 speed = 0 in SCROLL SHALL hold all positions while the LFSR still advances.
REQ-028 The integrator SHALL keep speed < SCREEN_W/NUM_PIPES so that at most one pipe wraps per tick.
REQ-029 Score event: old pipe_x[i]+PIPE_W >= bird_x and new pipe_x[i]+PIPE_W < bird_x, using 12-bit sums.
REQ-030 A score event SHALL set score_pulse for exactly one tick; score increments, saturating at 999.
REQ-031 A wrapping pipe SHALL NOT generate a score event in its wrap tick.
REQ-032 In IDLE and FROZEN, pipe_x, pipe_y, score and the LFSR SHALL hold, and score_pulse SHALL be 0.
REQ-033 frozen SHALL be asserted exactly when the state is FROZEN.

Reset
REQ-034 Reset and restart SHALL set state IDLE, pipe_x[i] = (i+1)*(SCREEN_W/NUM_PIPES)-1 (319 and 639 for the defaults), pipe_y[i] = (Y_MIN+Y_MAX)/2, score = 0, score_pulse = 0, and LFSR = seed.
REQ-035 Reset asserted mid-scroll SHALL take effect on the next edge, overriding all other inputs.

Structure
REQ-036 Package game_pkg SHALL hold the state enum (IDLE, SCROLL, FROZEN), LFSR_SEED, SCORE_MAX = 999 and the coordinate width (11).
REQ-037 The LFSR plus range-fold SHALL be sub-module gap_lfsr (ports: game_clk, reset, advance, gap_y).
REQ-038 Per-pipe move, wrap and score logic SHALL be a generate loop over NUM_PIPES with an OR-reduced score event.

Verification
REQ-039 Reset with defaults -> pipe_x = {319, 639}, pipe_y = {200, 200}, score = 0, frozen = 0.
REQ-040 enable = 1, speed = 1, one tick -> state SCROLL; the next tick gives pipe_x = {318, 638}.
REQ-041 pipe_x[0] = 2, speed = 3, SCROLL tick -> pipe_x[0] = 639 and pipe_y[0] in 100..300, equal to the gap_lfsr value.
REQ-042 bird_x = 100, speed = 1, pipe_x[0] 61->60 -> no pulse; 60->59 -> score_pulse = 1 for one tick, score = 1.
REQ-043 freeze and enable high together in SCROLL -> FROZEN with positions held; restart -> IDLE with REQ-034 values.
REQ-044 Score preloaded to 999 plus one score event -> score stays 999 and score_pulse = 1.
